// File: rtl/fir_serial_mc.sv
// fir_serial_mc: multi-channel bit-serial FIR filter.
//
// Samples arrive one bit per accepted cycle on i_din. Each complete sample is
// pushed into its channel's circular delay line and filtered against a shared
// coefficient bank with a single time-shared multiplier (one tap per cycle).
// The rounded and saturated result is returned one bit per consumed cycle on
// o_dout.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_en                  global enable; low freezes all state
//   i_din, i_din_valid    serial sample bit and its qualifier
//   i_ch                  channel of the incoming sample (taken with first bit)
//   o_ready               input bits are being accepted
//   o_dout, o_dout_valid  serial result bit and its qualifier
//   i_ready               downstream consumes the current o_dout bit
//   o_dout_ch             channel of the result being shifted out
//   o_sat                 the current result was clipped
//   i_coef_we/addr/data   coefficient bank write port (IDLE only)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for the first bit of a sample; coefficient writes open
// S_SHIFT_IN | collecting the remaining sample bits
// S_MAC      | one tap per cycle, k = 0..FIR_DEPTH-1
// S_ROUND    | round, saturate, load the output shift register
// S_SHIFT_OUT| presenting result bits to the sink

module fir_serial_mc #(
    parameter int DATA_WIDTH = 24,
    parameter int COEF_WIDTH = 18,
    parameter int FIR_DEPTH  = 32,
    parameter int NUM_CH     = 2,
    parameter int LSB_FIRST  = 1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW        = (FIR_DEPTH > 1) ? $clog2(FIR_DEPTH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_din,
    input  logic                  i_din_valid,
    input  logic [CH_W-1:0]       i_ch,
    output logic                  o_ready,
    output logic                  o_dout,
    output logic                  o_dout_valid,
    input  logic                  i_ready,
    output logic [CH_W-1:0]       o_dout_ch,
    output logic                  o_sat,
    input  logic                  i_coef_we,
    input  logic [AW-1:0]         i_coef_addr,
    input  logic [COEF_WIDTH-1:0] i_coef_data
);

    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = DATA_WIDTH + COEF_WIDTH + AW;
    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [AW-1:0]    K_LAST   = AW'(FIR_DEPTH - 1);
    localparam logic [AW:0]      DEPTH_W  = (AW + 1)'(FIR_DEPTH);

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(64'd1 << (COEF_WIDTH - 2));
    localparam logic signed [ACC_W-1:0] Y_MAX =
        {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN =
        {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_IN,
        S_MAC,
        S_ROUND,
        S_SHIFT_OUT
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [DATA_WIDTH-1:0]    din_sr_q, din_sr_d;
    logic [AW-1:0]            k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_WIDTH-1:0]    dout_sr_q, dout_sr_d;
    logic                     sat_q, sat_d;
    logic [CH_W-1:0]          dout_ch_q, dout_ch_d;

    logic signed [DATA_WIDTH-1:0] dline_q [NUM_CH][FIR_DEPTH];
    logic signed [COEF_WIDTH-1:0] coef_q  [FIR_DEPTH];
    logic [AW-1:0]                ptr_q   [NUM_CH];

    logic                     in_acc, out_acc;
    logic                     dline_we, ptr_adv, coef_wr;
    logic [DATA_WIDTH-1:0]    din_shift, dout_shift;
    logic [AW-1:0]            ptr_cur, tap_idx;
    logic [AW:0]              idx_sum;
    logic signed [DATA_WIDTH-1:0] tap;
    logic signed [COEF_WIDTH-1:0] coef_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext, acc_rnd, y_full;

    assign o_ready      = i_en & ((state_q == S_IDLE) | (state_q == S_SHIFT_IN));
    assign o_dout_valid = i_en & (state_q == S_SHIFT_OUT);
    assign in_acc       = i_din_valid & o_ready;
    assign out_acc      = i_ready & o_dout_valid;

    assign o_dout    = (LSB_FIRST != 0) ? dout_sr_q[0] : dout_sr_q[DATA_WIDTH-1];
    assign o_dout_ch = dout_ch_q;
    assign o_sat     = sat_q;

    assign din_shift  = (LSB_FIRST != 0) ? {i_din, din_sr_q[DATA_WIDTH-1:1]}
                                         : {din_sr_q[DATA_WIDTH-2:0], i_din};
    assign dout_shift = (LSB_FIRST != 0) ? {1'b0, dout_sr_q[DATA_WIDTH-1:1]}
                                         : {dout_sr_q[DATA_WIDTH-2:0], 1'b0};

    // Tap address (ptr - k) mod FIR_DEPTH; works for non-power-of-two depths.
    assign ptr_cur = ptr_q[ch_q];
    always_comb begin
        idx_sum = {1'b0, ptr_cur} + DEPTH_W - {1'b0, k_q};
        if (idx_sum >= DEPTH_W) begin
            idx_sum = idx_sum - DEPTH_W;
        end
        tap_idx = idx_sum[AW-1:0];
    end

    // At k=0 the new sample is only being written this cycle, so take it
    // straight from the deserialiser instead of the delay line.
    assign tap      = (k_q == '0) ? $signed(din_sr_q) : dline_q[ch_q][tap_idx];
    assign coef_sel = coef_q[k_q];
    assign prod     = $signed({{DATA_WIDTH{coef_sel[COEF_WIDTH-1]}}, coef_sel})
                    * $signed({{COEF_WIDTH{tap[DATA_WIDTH-1]}}, tap});
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    assign acc_rnd = acc_q + RND_HALF;
    assign y_full  = acc_rnd >>> (COEF_WIDTH - 1);

    assign dline_we = i_en & (state_q == S_MAC) & (k_q == '0);
    assign ptr_adv  = i_en & (state_q == S_MAC) & (k_q == K_LAST);
    assign coef_wr  = i_en & i_coef_we & (state_q == S_IDLE);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        ch_d      = ch_q;
        din_sr_d  = din_sr_q;
        k_d       = k_q;
        acc_d     = acc_q;
        dout_sr_d = dout_sr_q;
        sat_d     = sat_q;
        dout_ch_d = dout_ch_q;
        if (i_en) begin
            case (state_q)
                S_IDLE: begin
                    if (in_acc) begin
                        ch_d      = i_ch;
                        din_sr_d  = din_shift;
                        bit_cnt_d = CNT_W'(1);
                        state_d   = S_SHIFT_IN;
                    end
                end
                S_SHIFT_IN: begin
                    if (in_acc) begin
                        din_sr_d = din_shift;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            k_d       = '0;
                            state_d   = S_MAC;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_MAC: begin
                    acc_d = (k_q == '0) ? prod_ext : acc_q + prod_ext;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = S_ROUND;
                    end else begin
                        k_d = k_q + AW'(1);
                    end
                end
                S_ROUND: begin
                    if (y_full > Y_MAX) begin
                        dout_sr_d = Y_MAX[DATA_WIDTH-1:0];
                        sat_d     = 1'b1;
                    end else if (y_full < Y_MIN) begin
                        dout_sr_d = Y_MIN[DATA_WIDTH-1:0];
                        sat_d     = 1'b1;
                    end else begin
                        dout_sr_d = y_full[DATA_WIDTH-1:0];
                        sat_d     = 1'b0;
                    end
                    dout_ch_d = ch_q;
                    state_d   = S_SHIFT_OUT;
                end
                S_SHIFT_OUT: begin
                    if (out_acc) begin
                        dout_sr_d = dout_shift;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            state_d   = S_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            ch_q      <= '0;
            din_sr_q  <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            dout_sr_q <= '0;
            sat_q     <= 1'b0;
            dout_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            ch_q      <= ch_d;
            din_sr_q  <= din_sr_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            dout_sr_q <= dout_sr_d;
            sat_q     <= sat_d;
            dout_ch_q <= dout_ch_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ptr_q[c] <= '0;
                for (int k = 0; k < FIR_DEPTH; k++) begin
                    dline_q[c][k] <= '0;
                end
            end
            for (int k = 0; k < FIR_DEPTH; k++) begin
                coef_q[k] <= '0;
            end
        end else begin
            if (dline_we) begin
                dline_q[ch_q][ptr_cur] <= $signed(din_sr_q);
            end
            if (ptr_adv) begin
                ptr_q[ch_q] <= (ptr_cur == K_LAST) ? '0 : ptr_cur + AW'(1);
            end
            if (coef_wr) begin
                coef_q[i_coef_addr] <= $signed(i_coef_data);
            end
        end
    end

endmodule

// File: tb/tb_fir_serial_mc.sv
// Testbench for fir_serial_mc. Two instances share the stimulus wires: dut_l
// (LSB first) and dut_m (MSB first); `sel` routes the strobes and outputs to
// one of them. Expected results come from a direct convolution model.
module tb_fir_serial_mc;

    localparam int DW  = 24;
    localparam int CW  = 18;
    localparam int FD  = 32;
    localparam int NCH = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, din, din_valid, rdy_in, coef_we, sel;
    logic [0:0]  ch;
    logic [4:0]  coef_addr;
    logic [17:0] coef_data;

    logic        rdy_l, dout_l, vld_l, sat_l;
    logic [0:0]  dch_l;
    logic        rdy_m, dout_m, vld_m, sat_m;
    logic [0:0]  dch_m;
    logic        rdy_w, dout_w, vld_w, sat_w;
    logic [0:0]  dch_w;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    fir_serial_mc #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .FIR_DEPTH(FD), .NUM_CH(NCH), .LSB_FIRST(1)) dut_l (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_din(din), .i_din_valid(din_valid & ~sel),
        .i_ch(ch), .o_ready(rdy_l), .o_dout(dout_l), .o_dout_valid(vld_l), .i_ready(rdy_in & ~sel),
        .o_dout_ch(dch_l), .o_sat(sat_l), .i_coef_we(coef_we & ~sel), .i_coef_addr(coef_addr),
        .i_coef_data(coef_data));

    fir_serial_mc #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .FIR_DEPTH(FD), .NUM_CH(NCH), .LSB_FIRST(0)) dut_m (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_din(din), .i_din_valid(din_valid & sel),
        .i_ch(ch), .o_ready(rdy_m), .o_dout(dout_m), .o_dout_valid(vld_m), .i_ready(rdy_in & sel),
        .o_dout_ch(dch_m), .o_sat(sat_m), .i_coef_we(coef_we & sel), .i_coef_addr(coef_addr),
        .i_coef_data(coef_data));

    assign rdy_w  = sel ? rdy_m  : rdy_l;
    assign dout_w = sel ? dout_m : dout_l;
    assign vld_w  = sel ? vld_m  : vld_l;
    assign sat_w  = sel ? sat_m  : sat_l;
    assign dch_w  = sel ? dch_m  : dch_l;

    // Reference model: per instance coefficient set and per channel history,
    // hist[..][0] being the newest sample.
    int coef_mdl [2][FD];
    int hist_mdl [2][NCH][FD];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < FD; k++) begin
                coef_mdl[d][k] = 0;
                for (int c = 0; c < NCH; c++) hist_mdl[d][c][k] = 0;
            end
        end
    endtask

    task automatic model_step(input int d, input int c, input logic [DW-1:0] x,
                              output logic [DW-1:0] y, output logic s);
        longint acc, yl;
        for (int i = FD - 1; i > 0; i--) hist_mdl[d][c][i] = hist_mdl[d][c][i-1];
        hist_mdl[d][c][0] = int'($signed(x));
        acc = 0;
        for (int k = 0; k < FD; k++) acc += longint'(coef_mdl[d][k]) * longint'(hist_mdl[d][c][k]);
        yl = (acc + (longint'(1) << (CW - 2))) >>> (CW - 1);
        s  = 1'b0;
        if (yl > 64'sd8388607) begin
            yl = 64'sd8388607;
            s  = 1'b1;
        end else if (yl < -64'sd8388608) begin
            yl = -64'sd8388608;
            s  = 1'b1;
        end
        y = yl[DW-1:0];
    endtask

    task automatic write_coef(input int a, input int v);
        logic [17:0] vb;
        vb = 18'(v);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 5'(a);
        coef_data = vb;
        @(negedge clk);
        coef_we = 1'b0;
        coef_mdl[sel][a] = int'($signed(vb));
    endtask

    task automatic send_bits(input int c, input logic [DW-1:0] x, input bit gaps, input bit first_wr,
                             input logic [4:0] fw_a, input logic [17:0] fw_d, output int t_last);
        int  sent = 0;
        int  guard = 0;
        int  idx;
        bit  v;
        ch = 1'(c);
        while (sent < DW && guard < 400) begin
            @(negedge clk);
            guard++;
            coef_we = 1'b0;
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rdy_w !== 1'b1) v = 1'b0;
            idx = sel ? (DW - 1 - sent) : sent;
            din_valid = v;
            din = x[idx];
            if (v && sent == 0 && first_wr) begin
                coef_we   = 1'b1;
                coef_addr = fw_a;
                coef_data = fw_d;
            end
            if (v) sent++;
        end
        @(negedge clk);
        t_last    = cyc;
        din_valid = 1'b0;
        coef_we   = 1'b0;
        n_vec++;
        if (sent !== DW) begin
            n_err++;
            $display("FAIL send_accept: accepted %0d bits, required %0d", sent, DW);
        end
    endtask

    task automatic recv(input string tag, input int c, input logic [DW-1:0] exp_y, input logic exp_s,
                        input bit gaps, input int lat_cyc);
        logic [DW-1:0] got = '0;
        int   n = 0;
        int   guard = 0;
        bit   r;
        bit   stalled = 1'b0;
        logic pbit = 1'b0;
        while (vld_w !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        n_vec++;
        if (vld_w !== 1'b1) begin
            n_err++;
            $display("FAIL %s_timeout: o_dout_valid=%b after %0d cycles, required 1", tag, vld_w, guard);
        end else begin
            n_vec++;
            if (cyc !== lat_cyc) begin
                n_err++;
                $display("FAIL %s_latency: first valid at cycle %0d, required %0d", tag, cyc, lat_cyc);
            end
            n_vec++;
            if (dch_w !== 1'(c)) begin
                n_err++;
                $display("FAIL %s_ch: o_dout_ch=%0d, required %0d", tag, dch_w, c);
            end
            n_vec++;
            if (sat_w !== exp_s) begin
                n_err++;
                $display("FAIL %s_sat: o_sat=%b, required %b", tag, sat_w, exp_s);
            end
            while (n < DW && guard < 1500) begin
                r = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                rdy_in = r;
                if (stalled) begin
                    n_vec++;
                    if (dout_w !== pbit) begin
                        n_err++;
                        $display("FAIL %s_hold: o_dout=%b during stall, required %b", tag, dout_w, pbit);
                    end
                end
                if (vld_w === 1'b1 && r) begin
                    got[sel ? (DW - 1 - n) : n] = dout_w;
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = (vld_w === 1'b1);
                    pbit    = dout_w;
                end
                @(negedge clk);
                guard++;
            end
            rdy_in = 1'b0;
            n_vec++;
            if (got !== exp_y || n != DW) begin
                n_err++;
                $display("FAIL %s_data: got 0x%06h (%0d bits), required 0x%06h", tag, got, n, exp_y);
            end
            n_vec++;
            if (vld_w !== 1'b0) begin
                n_err++;
                $display("FAIL %s_done: o_dout_valid=%b after last bit, required 0", tag, vld_w);
            end
        end
    endtask

    task automatic do_sample(input string tag, input int c, input logic [DW-1:0] x, input bit gaps,
                             input bit en_gap, input bit mac_wr, input bit first_wr,
                             input logic [4:0] fw_a, input logic [17:0] fw_d);
        logic [DW-1:0] ey;
        logic          es;
        int            t;
        int            extra = 0;
        if (first_wr) coef_mdl[sel][fw_a] = int'($signed(fw_d));
        model_step(int'(sel), c, x, ey, es);
        send_bits(c, x, gaps, first_wr, fw_a, fw_d, t);
        if (en_gap) begin
            en = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                n_vec++;
                if (rdy_w !== 1'b0 || vld_w !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s_freeze: ready=%b valid=%b with i_en low, required 0 0", tag, rdy_w, vld_w);
                end
            end
            en    = 1'b1;
            extra = 5;
        end
        if (mac_wr) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                coef_we   = 1'b1;
                coef_addr = fw_a;
                coef_data = fw_d;
            end
            @(negedge clk);
            coef_we = 1'b0;
        end
        recv(tag, c, ey, es, gaps, t + FD + 1 + extra);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec += 10;
        if (rdy_l !== 1'b1 || rdy_m !== 1'b1) begin n_err++; $display("FAIL reset_ready: %b %b, required 1", rdy_l, rdy_m); end
        if (vld_l !== 1'b0 || vld_m !== 1'b0) begin n_err++; $display("FAIL reset_valid: %b %b, required 0", vld_l, vld_m); end
        if (dout_l !== 1'b0 || dout_m !== 1'b0) begin n_err++; $display("FAIL reset_dout: %b %b, required 0", dout_l, dout_m); end
        if (dch_l !== 1'b0 || dch_m !== 1'b0) begin n_err++; $display("FAIL reset_ch: %b %b, required 0", dch_l, dch_m); end
        if (sat_l !== 1'b0 || sat_m !== 1'b0) begin n_err++; $display("FAIL reset_sat: %b %b, required 0", sat_l, sat_m); end
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b0;
        #1;
        if (rdy_l !== 1'b0) begin n_err++; $display("FAIL en_ready: o_ready=%b with i_en low, required 0", rdy_l); end
        en = 1'b1;
        #1;
        if (rdy_l !== 1'b1) begin n_err++; $display("FAIL en_resume: o_ready=%b, required 1", rdy_l); end
        if (vld_l !== 1'b0) begin n_err++; $display("FAIL idle_valid: o_dout_valid=%b, required 0", vld_l); end
        if (rdy_m !== 1'b1) begin n_err++; $display("FAIL idle_ready_m: o_ready=%b, required 1", rdy_m); end
        if (vld_m !== 1'b0) begin n_err++; $display("FAIL idle_valid_m: o_dout_valid=%b, required 0", vld_m); end
    endtask

    task automatic test_impulse();
        sel = 1'b0;
        for (int k = 0; k < FD; k++) write_coef(k, k * 2048);
        for (int i = 0; i < FD; i++) do_sample("impulse", 0, (i == 0) ? 24'h100000 : 24'h0, 0, 0, 0, 0, 5'd0, 18'd0);
    endtask

    task automatic test_channel_isolation();
        sel = 1'b0;
        for (int i = 0; i < FD; i++) begin
            do_sample("iso_ch1", 1, (i == 0) ? 24'h100000 : 24'h0, 0, 0, 0, 0, 5'd0, 18'd0);
            do_sample("iso_ch0", 0, 24'h0, 0, 0, 0, 0, 5'd0, 18'd0);
        end
    endtask

    task automatic test_saturation();
        sel = 1'b0;
        for (int k = 0; k < FD; k++) write_coef(k, 131071);
        for (int i = 0; i < FD; i++) do_sample("sat_pos", 0, 24'h7FFFFF, 0, 0, 0, 0, 5'd0, 18'd0);
        for (int i = 0; i < FD; i++) do_sample("sat_neg", 0, 24'h800000, 0, 0, 0, 0, 5'd0, 18'd0);
    endtask

    task automatic test_handshake();
        sel = 1'b0;
        for (int k = 0; k < FD; k++) write_coef(k, int'($urandom_range(0, 8191)) - 4096);
        for (int i = 0; i < 12; i++)
            do_sample("stress", int'($urandom_range(0, 1)), 24'($urandom), 1, (i % 4) == 1, 0, 0, 5'd0, 18'd0);
    endtask

    task automatic test_coef_write_in_mac();
        logic [17:0] v;
        sel = 1'b1;
        for (int k = 0; k < FD; k++) write_coef(k, int'($urandom_range(0, 8191)) - 4096);
        v = 18'h1F000 | 18'($urandom_range(0, 255));
        do_sample("mac_wr", 1, 24'($urandom), 0, 0, 1, 0, 5'd0, v);
        do_sample("after_mac_wr", 0, 24'($urandom), 0, 0, 0, 0, 5'd0, 18'd0);
        v = 18'h00800 | 18'($urandom_range(0, 255));
        do_sample("first_bit_wr", 1, 24'($urandom), 1, 0, 0, 1, 5'd0, v);
        do_sample("after_first_wr", 1, 24'($urandom), 0, 0, 0, 0, 5'd0, 18'd0);
    endtask

    task automatic test_reset_mid_out();
        int t;
        int guard = 0;
        int n = 0;
        sel = 1'b0;
        send_bits(0, 24'h100000, 0, 0, 5'd0, 18'd0, t);
        while (vld_l !== 1'b1 && guard < 300) begin @(negedge clk); guard++; end
        n_vec++;
        if (vld_l !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_reach: o_dout_valid=%b, required 1", vld_l);
        end
        while (n < 5 && guard < 600) begin
            rdy_in = 1'b1;
            if (vld_l === 1'b1) n++;
            @(negedge clk);
            guard++;
        end
        rdy_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec += 3;
        if (vld_l !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: o_dout_valid=%b, required 0", vld_l); end
        if (dout_l !== 1'b0) begin n_err++; $display("FAIL rst_mid_dout: o_dout=%b, required 0", dout_l); end
        if (rdy_l !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: o_ready=%b, required 1", rdy_l); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_sample("post_rst_ch0", 0, 24'h100000, 0, 0, 0, 0, 5'd0, 18'd0);
        do_sample("post_rst_ch1", 1, 24'h7FFFFF, 0, 0, 0, 0, 5'd0, 18'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        rdy_in    = 1'b0;
        coef_we   = 1'b0;
        sel       = 1'b0;
        ch        = 1'b0;
        coef_addr = 5'd0;
        coef_data = 18'd0;
        model_reset();
        test_reset();
        test_impulse();
        test_channel_isolation();
        test_saturation();
        test_handshake();
        test_coef_write_in_mac();
        test_reset_mid_out();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fir_serial_mc.md
# fir_serial_mc

Multi-channel, bit-serial FIR filter. It deserialises samples on a 1-bit input and filters each one against a per-channel delay line, using one time-shared multiplier and a runtime-loadable coefficient bank. Each result is returned bit-serially under a ready/valid handshake. It is the parametrised successor of the single-channel serial `top_level` FIR: it adds channel count, coefficient width, bit order and saturation reporting. It sits between the serial sample source and the serial sink.

## Interface
- DATA_WIDTH, 24, sample width, signed two's complement
- COEF_WIDTH, 18, coefficient width, signed Q1.(COEF_WIDTH-1)
- FIR_DEPTH, 32, number of taps (≥2)
- NUM_CH, 2, independent channels (≥1); CH_W = max(1, $clog2(NUM_CH))
- LSB_FIRST, 1, serial bit order for both input and output (1 = LSB first, 0 = MSB first)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_en  in  1  global enable; low freezes all state, forces o_ready=0 and o_dout_valid=0
- i_din  in  1  serial sample bit
- i_din_valid  in  1  qualifies i_din; bit accepted when i_din_valid & o_ready & i_en
- i_ch  in  CH_W  channel of incoming sample; sampled with first accepted bit
- o_ready  out  1  filter accepts input bits (IDLE or SHIFT_IN)
- o_dout  out  1  serial result bit
- o_dout_valid  out  1  o_dout valid; bit consumed when o_dout_valid & i_ready
- i_ready  in  1  downstream accepts current o_dout bit
- o_dout_ch  out  CH_W  channel of the result being shifted out
- o_sat  out  1  current result was saturated; valid while o_dout_valid
- i_coef_we  in  1  coefficient write strobe; honoured only in IDLE
- i_coef_addr  in  $clog2(FIR_DEPTH)  tap index k
- i_coef_data  in  COEF_WIDTH  h[k]

## Operation
- FSM: IDLE → SHIFT_IN → MAC → ROUND → SHIFT_OUT → IDLE.
- **IDLE**
  - o_ready=1.
  - An accepted bit captures i_ch and moves to SHIFT_IN with bit count 1.
  - Coefficient writes occur only here.
- **SHIFT_IN**
  - o_ready=1; gaps in i_din_valid pause the count.
  - Bit j goes into sample bit j (LSB_FIRST=1) or DATA_WIDTH-1-j (LSB_FIRST=0).
  - After DATA_WIDTH accepted bits → MAC.
- **MAC**
  - FIR_DEPTH cycles, k = 0..FIR_DEPTH-1.
  - At k=0, the new sample x[n] is written to buf[ch][ptr[ch]].
  - acc += h[k] · buf[ch][(ptr[ch] − k) mod FIR_DEPTH], signed.
  - Accumulator width DATA_WIDTH+COEF_WIDTH+$clog2(FIR_DEPTH); overflow is impossible.
  - On exit, ptr[ch] increments, wrapping FIR_DEPTH−1 → 0.
- **ROUND** (1 cycle)
  - y = (acc + 2^(COEF_WIDTH−2)) >>> (COEF_WIDTH−1).
  - Saturate y to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]; o_sat=1 if clipped.
  - Load the output shift register; latch o_dout_ch.
- **SHIFT_OUT**
  - o_dout_valid=1.
  - Each consumed bit advances in the same bit order as input.
  - After DATA_WIDTH consumed bits → IDLE.
  - i_ready low stalls with o_dout held.
- Channel delay lines and pointers are fully independent. Coefficients are shared by all channels.
- i_coef_we outside IDLE is ignored, and no write occurs.
- Reset values:
  - FSM IDLE.
  - All delay lines, pointers, coefficients and accumulator zero.
  - o_ready=1 (o_ready follows FSM and i_en).
  - o_dout=0, o_dout_valid=0, o_dout_ch=0, o_sat=0.
- Reset mid-operation: asynchronous return to reset state. The partial sample is discarded and the delay line is cleared.

## Timing
- o_ready, o_dout_valid: combinational from FSM state and i_en only. No combinational path from i_din_valid or i_ready.
- Last input bit accepted at edge T:
  - MAC occupies cycles T+1..T+FIR_DEPTH.
  - ROUND is cycle T+FIR_DEPTH+1.
  - o_dout_valid first high in cycle T+FIR_DEPTH+2.
- Minimum sample period (no stalls): 2·DATA_WIDTH+FIR_DEPTH+1 cycles. Defaults: 81.
- Coefficient write takes effect at the next edge. A write in the same cycle the first input bit is accepted is honoured (state is still IDLE).
- i_en low: no state advances. Resuming i_en continues exactly where frozen.

## Test plan
- **Impulse response, ch0**
  - Stimulus: h[k]=k·2^(COEF_WIDTH−1)/64; send x=2^20 followed by 31 zeros.
  - Required: outputs equal 2^20·k/64 for k=0..31, o_sat=0.
- **Saturation**
  - Stimulus: all h[k]=2^(COEF_WIDTH−1)−1; feed 32 samples of 0x7FFFFF.
  - Required: outputs rise, then clip to 0x7FFFFF with o_sat=1. Then feed 0x800000 ×32; required: settles to 0x800000, o_sat=1.
- **Channel isolation**
  - Stimulus: interleave impulse on ch1 with zeros on ch0.
  - Required: ch0 outputs all 0; ch1 reproduces h. o_dout_ch matches each input channel.
- **Handshake stress**
  - Stimulus: random gaps on i_din_valid and i_ready.
  - Required: results bit-identical to the no-stall run; first o_dout_valid exactly FIR_DEPTH+2 cycles after last accepted bit.
- **Coefficient write in MAC, with LSB_FIRST=0**
  - Stimulus: write h[0] during MAC.
  - Required: write ignored, result unchanged. MSB-first ordering is verified on both ports.
- **Reset mid-SHIFT_OUT**
  - Stimulus: deassert i_rst_n during SHIFT_OUT.
  - Required: o_dout_valid=0 immediately. Subsequent impulse output matches a fresh filter with all-zero coefficients, i.e. 0.
